// File: rtl/exhaust_ctrl_multilevel.sv
// Range-hood exhaust fan controller with NUM_LEVELS fan levels.
// The top level is a timed boost that may be used once per power-on. Leaving
// boost early with the menu key enters a timed return-to-idle phase. Both
// timers count the external 1 Hz tick. Every output is registered and is
// decoded from the next state, so outputs change on the same edge as the state.
module exhaust_ctrl_multilevel #(
  parameter int NUM_LEVELS  = 3,
  parameter int LVL_W       = 2,
  parameter int BOOST_SECS  = 60,
  parameter int RETURN_SECS = 60,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             power_on,
  input  logic             menu_key,
  input  logic             level_req,
  input  logic [LVL_W-1:0] level_sel,
  output logic [2:0]       state,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] countdown,
  output logic             countdown_active,
  output logic             busy,
  output logic             in_select,
  output logic             boost_used
);

  localparam int MAX_SECS = (BOOST_SECS > RETURN_SECS) ? BOOST_SECS : RETURN_SECS;

  // Parameters that cannot work are rejected at elaboration
  if (NUM_LEVELS < 2) begin : g_chk_levels
    $fatal(1, "NUM_LEVELS must be at least 2");
  end
  if ((64'd1 << LVL_W) <= 64'(NUM_LEVELS)) begin : g_chk_lvl_w
    $fatal(1, "LVL_W too narrow for NUM_LEVELS");
  end
  if (BOOST_SECS < 1) begin : g_chk_boost
    $fatal(1, "BOOST_SECS must be at least 1");
  end
  if (RETURN_SECS < 1) begin : g_chk_return
    $fatal(1, "RETURN_SECS must be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(MAX_SECS)) begin : g_chk_cnt_w
    $fatal(1, "CNT_W too narrow for the longest countdown");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_RUN    = 3'd2,
    ST_BOOST  = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  localparam logic [LVL_W-1:0] LVL_OFF   = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_BOOST = LVL_W'(NUM_LEVELS);
  localparam logic [LVL_W-1:0] LVL_HIGH  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_BOOST = CNT_W'(BOOST_SECS);
  localparam logic [CNT_W-1:0] CNT_RET   = CNT_W'(RETURN_SECS);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boost_used_q, boost_used_d;
  logic             power_q;
  logic             cact_q, busy_q, in_select_q;

  logic             power_rise;
  logic             sel_valid;
  logic             req_cont;
  logic             req_boost;
  logic             timer_expire;

  // Request qualification and power-edge detection
  always_comb begin
    power_rise   = power_on & ~power_q;
    sel_valid    = (level_sel >= LVL_ONE) && (level_sel <= LVL_BOOST);
    req_cont     = level_req & sel_valid & (level_sel != LVL_BOOST);
    req_boost    = level_req & sel_valid & (level_sel == LVL_BOOST) & ~boost_used_q;
    timer_expire = tick_1hz & (cnt_q <= CNT_ONE);
  end

  // Next-state logic; power handling takes precedence over the state machine
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    boost_used_d = boost_used_q;
    if (!power_on) begin
      state_d = ST_IDLE;
      level_d = LVL_OFF;
      cnt_d   = CNT_ZERO;
    end else if (power_rise) begin
      state_d      = ST_IDLE;
      level_d      = LVL_OFF;
      cnt_d        = CNT_ZERO;
      boost_used_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (menu_key) begin
            state_d = ST_SELECT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SELECT, ST_RUN: begin
          if (menu_key) begin
            state_d = ST_IDLE;
            level_d = LVL_OFF;
          end else if (req_cont) begin
            state_d = ST_RUN;
            level_d = level_sel;
          end else if (req_boost) begin
            state_d      = ST_BOOST;
            level_d      = LVL_BOOST;
            cnt_d        = CNT_BOOST;
            boost_used_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        ST_BOOST: begin
          // Expiry beats a coincident menu key
          if (timer_expire) begin
            state_d = ST_RUN;
            level_d = LVL_HIGH;
            cnt_d   = CNT_ZERO;
          end else if (menu_key) begin
            state_d = ST_RETURN;
            level_d = LVL_HIGH;
            cnt_d   = CNT_RET;
          end else if (tick_1hz) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RETURN: begin
          if (timer_expire) begin
            state_d = ST_IDLE;
            level_d = LVL_OFF;
            cnt_d   = CNT_ZERO;
          end else if (tick_1hz) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = LVL_OFF;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State register with output flags decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      level_q      <= LVL_OFF;
      cnt_q        <= CNT_ZERO;
      boost_used_q <= 1'b0;
      power_q      <= 1'b0;
      cact_q       <= 1'b0;
      busy_q       <= 1'b0;
      in_select_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      boost_used_q <= boost_used_d;
      power_q      <= power_on;
      cact_q       <= (state_d == ST_BOOST) || (state_d == ST_RETURN);
      busy_q       <= (state_d == ST_RUN) || (state_d == ST_BOOST) || (state_d == ST_RETURN);
      in_select_q  <= (state_d == ST_SELECT);
    end
  end

  assign state            = state_q;
  assign level            = level_q;
  assign countdown        = cnt_q;
  assign countdown_active = cact_q;
  assign busy             = busy_q;
  assign in_select        = in_select_q;
  assign boost_used       = boost_used_q;

endmodule

// File: tb/tb_exhaust_ctrl_multilevel.sv
// Self-checking bench for exhaust_ctrl_multilevel: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_exhaust_ctrl_multilevel;

  localparam int NL  = 3;
  localparam int LW  = 3;
  localparam int BS  = 5;
  localparam int RS  = 3;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_1hz = 1'b0;
  logic          power_on = 1'b0;
  logic          menu_key = 1'b0;
  logic          level_req = 1'b0;
  logic [LW-1:0] level_sel = '0;
  logic [2:0]    state;
  logic [LW-1:0] level;
  logic [CW-1:0] countdown;
  logic          countdown_active;
  logic          busy;
  logic          in_select;
  logic          boost_used;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 select, 2 run, 3 boost, 4 return
  int m_mode = 0;
  int m_run_level = 0;
  int m_secs = 0;
  int m_used = 0;
  int m_prev_pwr = 0;

  exhaust_ctrl_multilevel #(
    .NUM_LEVELS(NL), .LVL_W(LW), .BOOST_SECS(BS), .RETURN_SECS(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .power_on(power_on),
    .menu_key(menu_key), .level_req(level_req), .level_sel(level_sel),
    .state(state), .level(level), .countdown(countdown),
    .countdown_active(countdown_active), .busy(busy), .in_select(in_select),
    .boost_used(boost_used)
  );

  always #5 clk = ~clk;

  function automatic int fan_level();
    case (m_mode)
      2:       return m_run_level;
      3:       return NL;
      4:       return NL - 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int sel;
    bit valid;
    bit boost_ok;
    sel      = int'(level_sel);
    valid    = level_req && sel >= 1 && sel <= NL;
    boost_ok = valid && sel == NL && m_used == 0;
    if (rst) begin
      m_mode = 0; m_run_level = 0; m_secs = 0; m_used = 0; m_prev_pwr = 0;
      return;
    end
    if (!power_on) begin
      m_mode = 0; m_secs = 0;
    end else if (m_prev_pwr == 0) begin
      m_mode = 0; m_secs = 0; m_used = 0;
    end else if (m_mode == 0) begin
      if (menu_key) m_mode = 1;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (menu_key) m_mode = 0;
      else if (valid && sel < NL) begin m_mode = 2; m_run_level = sel; end
      else if (boost_ok) begin m_mode = 3; m_secs = BS; m_used = 1; end
    end else if (m_mode == 3) begin
      if (tick_1hz && m_secs == 1) begin m_mode = 2; m_run_level = NL - 1; m_secs = 0; end
      else if (menu_key) begin m_mode = 4; m_secs = RS; end
      else if (tick_1hz) m_secs--;
    end else begin
      if (tick_1hz && m_secs == 1) begin m_mode = 0; m_secs = 0; end
      else if (tick_1hz) m_secs--;
    end
    m_prev_pwr = power_on ? 1 : 0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("state", int'(state), m_mode);
    check("level", int'(level), fan_level());
    check("countdown", int'(countdown), m_secs);
    check("countdown_active", int'(countdown_active), (m_mode == 3 || m_mode == 4) ? 1 : 0);
    check("busy", int'(busy), (m_mode >= 2) ? 1 : 0);
    check("in_select", int'(in_select), (m_mode == 1) ? 1 : 0);
    check("boost_used", int'(boost_used), m_used);
  endtask

  // One clock: drive inputs, advance model, sample after the edge
  task automatic cyc(input bit r, input bit p, input bit t, input bit m,
                     input bit q, input int s);
    rst = r; power_on = p; tick_1hz = t; menu_key = m; level_req = q;
    level_sel = LW'(s);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset, then power rising edge consumed
    cyc(1, 1, 0, 0, 0, 0);
    check("rst_state", int'(state), 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    check("sel_state", int'(state), 1);
    cyc(0, 1, 0, 0, 1, 2);
    check("run_level", int'(level), 2);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    // boost and full expiry
    cyc(0, 1, 0, 0, 1, 3);
    check("boost_cnt", int'(countdown), BS);
    for (int i = 0; i < BS; i++) cyc(0, 1, 1, 0, 0, 0);
    check("boost_expired_state", int'(state), 2);
    check("boost_expired_level", int'(level), 2);
    cyc(0, 1, 0, 0, 1, 3);
    check("second_boost_ignored", int'(state), 2);
    // power cycle, boost, early exit to return
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    check("return_cnt", int'(countdown), RS);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 1, 1, 0, 0, 0);
    check("return_cnt2", int'(countdown), 2);
    cyc(0, 0, 0, 0, 0, 0);
    check("power_drop_state", int'(state), 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("power_rise_used", int'(boost_used), 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    for (int i = 0; i < BS - 1; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0);
    check("expiry_wins", int'(state), 2);
    // return phase runs to completion
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    cyc(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < RS; i++) cyc(0, 1, 1, 0, 0, 0);
    check("return_done_busy", int'(busy), 0);
    // out-of-range and priority
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 7);
    check("out_of_range", int'(state), 1);
    cyc(0, 1, 0, 1, 1, 1);
    check("menu_beats_req", int'(state), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 3);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("rst_mid_boost", int'(countdown), 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 59) != 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 7)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
